// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// mem_lsu_pkg: access-op encoding, FSM states and decode helpers for mem_lsu.
// Rev 1.0
// ============================================================================
package mem_lsu_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return lo[0];
      MEM_LW, MEM_SW:          return |lo;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_fmt.sv
`default_nettype none
// ============================================================================
// mem_lsu_fmt: selects the addressed byte/half of read data and extends it.
// Rev 1.0
// ============================================================================
module mem_lsu_fmt
  import mem_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [3:0]  op,
  input  logic [1:0]  lo,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lo, 3'b000} +: 8];
    half_sel = lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: result = {24'h0, byte_sel};
      MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// mem_lsu: memory-stage load/store unit driving a req/gnt/rvalid data bus.
// Rev 1.0
// ============================================================================
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [3:0]             mem_op_i,
  output logic                   stall_o,
  output logic                   misalign_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o,
  output logic                   dbus_req_o,
  output logic                   dbus_we_o,
  output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
  output logic [3:0]             dbus_be_o,
  output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
  input  logic                   dbus_gnt_i,
  input  logic                   dbus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  dbus_rdata_i
);

  state_e                 state;
  state_e                 state_nxt;
  logic [3:0]             op_q;
  logic [1:0]             lo_q;
  logic [RADDR_WIDTH-1:0] waddr_q;
  logic                   we_q;
  logic                   access;
  logic                   misaligned;
  logic                   start;
  logic [3:0]             be_nxt;
  logic [DATA_WIDTH-1:0]  wdata_nxt;
  logic [DATA_WIDTH-1:0]  load_data;

  // The op field is authoritative; the redundant store flag is not consulted.
  logic unused_mem_we;
  assign unused_mem_we = mem_we_i;

  assign access     = is_load(mem_op_i) | is_store(mem_op_i);
  assign misaligned = access & is_misaligned(mem_op_i, mem_addr_i[1:0]);
  assign start      = access & ~misaligned;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_REQ;
      ST_REQ:  if (dbus_gnt_i) state_nxt = dbus_we_o ? ST_DONE : ST_WAIT;
      ST_WAIT: if (dbus_rvalid_i) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_o = 1'b0;
    case (state)
      ST_IDLE:         stall_o = start;
      ST_REQ, ST_WAIT: stall_o = 1'b1;
      default:         stall_o = 1'b0;
    endcase
  end

  // Loads get lane enables too, so the bus sees the access width.
  always_comb begin
    be_nxt    = 4'b0000;
    wdata_nxt = '0;
    case (mem_op_i)
      MEM_LB, MEM_LBU: be_nxt = 4'b0001 << mem_addr_i[1:0];
      MEM_LH, MEM_LHU: be_nxt = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      MEM_LW:          be_nxt = 4'b1111;
      MEM_SB: begin
        be_nxt    = 4'b0001 << mem_addr_i[1:0];
        wdata_nxt = {4{mem_data_i[7:0]}};
      end
      MEM_SH: begin
        be_nxt    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{mem_data_i[15:0]}};
      end
      MEM_SW: begin
        be_nxt    = 4'b1111;
        wdata_nxt = mem_data_i;
      end
      default: ;
    endcase
  end

  mem_lsu_fmt u_fmt (
    .rdata  (dbus_rdata_i),
    .op     (op_q),
    .lo     (lo_q),
    .result (load_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_waddr_o  <= '0;
      reg_we_o     <= 1'b0;
      reg_wdata_o  <= '0;
      misalign_o   <= 1'b0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
      op_q         <= MEM_NOP;
      lo_q         <= 2'b00;
      waddr_q      <= '0;
      we_q         <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= is_store(mem_op_i);
            dbus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
            dbus_be_o    <= be_nxt;
            dbus_wdata_o <= wdata_nxt;
            op_q         <= mem_op_i;
            lo_q         <= mem_addr_i[1:0];
            waddr_q      <= reg_waddr_i;
            we_q         <= reg_we_i;
            reg_we_o     <= 1'b0;
          end else if (misaligned) begin
            misalign_o <= 1'b1;
            reg_we_o   <= 1'b0;
          end else begin
            reg_waddr_o <= reg_waddr_i;
            reg_we_o    <= reg_we_i;
            reg_wdata_o <= reg_wdata_i;
          end
        end
        ST_REQ: begin
          if (dbus_gnt_i) begin
            dbus_req_o <= 1'b0;
            if (dbus_we_o) begin
              reg_waddr_o <= waddr_q;
              reg_we_o    <= reg_we_i;
              reg_wdata_o <= reg_wdata_i;
            end
          end
        end
        ST_WAIT: begin
          if (dbus_rvalid_i) begin
            reg_waddr_o <= waddr_q;
            reg_we_o    <= we_q;
            reg_wdata_o <= load_data;
          end
        end
        ST_DONE: reg_we_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_lsu: scoreboard bench with a byte-level memory reference model.
// Rev 1.0
// ============================================================================
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [3:0]  mem_op_i;
  logic        stall_o;
  logic        misalign_o;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .reg_waddr_i   (reg_waddr_i),
    .reg_we_i      (reg_we_i),
    .reg_wdata_i   (reg_wdata_i),
    .mem_we_i      (mem_we_i),
    .mem_addr_i    (mem_addr_i),
    .mem_data_i    (mem_data_i),
    .mem_op_i      (mem_op_i),
    .stall_o       (stall_o),
    .misalign_o    (misalign_o),
    .reg_waddr_o   (reg_waddr_o),
    .reg_we_o      (reg_we_o),
    .reg_wdata_o   (reg_wdata_o),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_be_o     (dbus_be_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .dbus_gnt_i    (dbus_gnt),
    .dbus_rvalid_i (dbus_rvalid),
    .dbus_rdata_i  (dbus_rdata)
  );

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  wb_t         wb_q[$];
  bus_t        bus_q[$];
  logic [31:0] mis_q[$];

  logic [31:0] busmem[16];
  logic [7:0]  refmem[64];

  int gnt_mode = 0;   // 0 random, 1 immediate, 2 after gnt_wait cycles, 3 never
  int gnt_wait = 0;
  int rv_max   = 2;
  bit hold_rv  = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    busmem[idx] = v;
    for (int b = 0; b < 4; b++) refmem[idx*4 + b] = v[8*b +: 8];
  endtask

  // Bus slave: grants per gnt_mode, returns read data 0..rv_max cycles later.
  initial begin
    int         req_cycles;
    bit         pend;
    int         dly;
    logic [3:0] ridx;
    bit         g;
    req_cycles  = 0;
    pend        = 1'b0;
    dly         = 0;
    ridx        = '0;
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
    dbus_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      dbus_gnt    = 1'b0;
      dbus_rvalid = 1'b0;
      if (pend && !hold_rv) begin
        if (dly == 0) begin
          dbus_rvalid = 1'b1;
          dbus_rdata  = busmem[ridx];
          pend        = 1'b0;
        end else begin
          dly--;
        end
      end
      if (dbus_req_o && !pend) begin
        case (gnt_mode)
          0:       g = ($urandom_range(0, 2) != 0);
          1:       g = 1'b1;
          2:       g = (req_cycles >= gnt_wait);
          default: g = 1'b0;
        endcase
        if (g) begin
          dbus_gnt   = 1'b1;
          req_cycles = 0;
          if (dbus_we_o) begin
            for (int b = 0; b < 4; b++)
              if (dbus_be_o[b]) busmem[dbus_addr_o[5:2]][8*b +: 8] = dbus_wdata_o[8*b +: 8];
          end else begin
            pend = 1'b1;
            ridx = dbus_addr_o[5:2];
            dly  = $urandom_range(0, rv_max);
          end
        end else begin
          req_cycles++;
        end
      end
    end
  end

  // Monitor: writebacks, misalign pulses, bus handshakes, request stability.
  initial begin
    wb_t  e;
    bus_t eb;
    bus_t prev;
    logic prev_req;
    logic prev_gnt;
    prev_req = 1'b0;
    prev_gnt = 1'b0;
    prev     = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (reg_we_o) begin
          if (wb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wb_unexpected: got write x%0d=%h, required none at %0t",
                     reg_waddr_o, reg_wdata_o, $time);
          end else begin
            e = wb_q.pop_front();
            check("wb_waddr", 32'(reg_waddr_o), 32'(e.waddr));
            check("wb_wdata", reg_wdata_o, e.wdata);
          end
        end
        if (misalign_o) begin
          n_vec++;
          if (mis_q.size() == 0) begin
            n_err++;
            $display("FAIL misalign_unexpected: got pulse, required none at %0t", $time);
          end else begin
            void'(mis_q.pop_front());
          end
        end
        if (dbus_req_o && dbus_gnt) begin
          if (bus_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL bus_unexpected: got request addr %h, required none at %0t",
                     dbus_addr_o, $time);
          end else begin
            eb = bus_q.pop_front();
            check("bus_we", 32'(dbus_we_o), 32'(eb.we));
            check("bus_addr", dbus_addr_o, eb.addr);
            if (eb.we) begin
              check("bus_be", 32'(dbus_be_o), 32'(eb.be));
              check("bus_wdata", dbus_wdata_o, eb.wdata);
            end
          end
        end
        if (dbus_req_o && prev_req && !prev_gnt) begin
          check("req_stable_addr", dbus_addr_o, prev.addr);
          check("req_stable_be", 32'(dbus_be_o), 32'(prev.be));
          check("req_stable_wdata", dbus_wdata_o, prev.wdata);
          check("req_stable_we", 32'(dbus_we_o), 32'(prev.we));
        end
        prev_req = dbus_req_o;
        prev_gnt = dbus_gnt;
        prev     = '{we: dbus_we_o, addr: dbus_addr_o, be: dbus_be_o, wdata: dbus_wdata_o};
      end else begin
        prev_req = 1'b0;
      end
    end
  end

  // Reference model + driver: pushes expectations, then holds the op until accepted.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit chk_lat, input int extra);
    int          sz;
    int          a;
    int          exp_lat;
    int          lat;
    bit          acc;
    bit          st;
    logic [31:0] ld;
    bus_t        b;
    st = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    if (op == MEM_LB || op == MEM_LBU || op == MEM_SB)      sz = 1;
    else if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) sz = 2;
    else if (op == MEM_LW || op == MEM_SW)                  sz = 4;
    else                                                    sz = 0;
    a = int'(addr[5:0]);
    if (sz == 0) begin
      if (we) wb_q.push_back('{waddr: wa, wdata: wd});
      exp_lat = 1;
    end else if ((a % sz) != 0) begin
      mis_q.push_back(addr);
      exp_lat = 1;
    end else begin
      b.we    = st;
      b.addr  = {addr[31:2], 2'b00};
      b.be    = 4'(((1 << sz) - 1) << (a % 4));
      b.wdata = '0;
      if (st) begin
        if (sz == 1)      b.wdata = 32'(data[7:0]) * 32'h0101_0101;
        else if (sz == 2) b.wdata = 32'(data[15:0]) * 32'h0001_0001;
        else              b.wdata = data;
        for (int k = 0; k < sz; k++) refmem[a + k] = data[8*k +: 8];
        if (we) wb_q.push_back('{waddr: wa, wdata: wd});
        exp_lat = 3;
      end else begin
        ld = '0;
        for (int k = 0; k < sz; k++) ld = ld | (32'(refmem[a + k]) << (8*k));
        if ((op == MEM_LB || op == MEM_LH) && ld[8*sz - 1]) ld = ld | (32'hFFFF_FFFF << (8*sz));
        if (we) wb_q.push_back('{waddr: wa, wdata: ld});
        exp_lat = 4;
      end
      bus_q.push_back(b);
    end
    mem_op_i    = op;
    mem_addr_i  = addr;
    mem_data_i  = data;
    mem_we_i    = st;
    reg_we_i    = we;
    reg_waddr_i = wa;
    reg_wdata_i = wd;
    lat = 0;
    acc = 1'b0;
    while (!acc && lat < 200) begin
      @(negedge clk);
      acc = !stall_o;
      @(posedge clk);
      lat++;
      #1;
    end
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no accept after %0d cycles, required accept", lat);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "op never accepted");
    end
    if (chk_lat || exp_lat == 1) check("latency", lat, exp_lat + extra);
  endtask

  task automatic idle_inputs();
    mem_op_i    = MEM_NOP;
    mem_addr_i  = '0;
    mem_data_i  = '0;
    mem_we_i    = 1'b0;
    reg_we_i    = 1'b0;
    reg_waddr_i = '0;
    reg_wdata_i = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    check("rst_reg_we", 32'(reg_we_o), 32'd0);
    check("rst_reg_waddr", 32'(reg_waddr_o), 32'd0);
    check("rst_reg_wdata", reg_wdata_o, 32'd0);
    check("rst_req", 32'(dbus_req_o), 32'd0);
    check("rst_bus_we", 32'(dbus_we_o), 32'd0);
    check("rst_bus_addr", dbus_addr_o, 32'd0);
    check("rst_bus_be", 32'(dbus_be_o), 32'd0);
    check("rst_bus_wdata", dbus_wdata_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    gnt_mode = 1;
    rv_max   = 0;
    issue(MEM_NOP, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234, 1'b1, 0);
    gnt_mode = 2;
    gnt_wait = 2;
    issue(MEM_SB, 32'h1003, 32'hAB, 1'b0, 5'd0, 32'h0, 1'b1, 2);
    gnt_mode = 1;
    set_word(0, 32'h0000_8000);
    issue(MEM_LB, 32'h2001, 32'h0, 1'b1, 5'd7, 32'h0, 1'b1, 0);
    issue(MEM_LBU, 32'h2001, 32'h0, 1'b1, 5'd8, 32'h0, 1'b1, 0);
    set_word(0, 32'hBEEF_0000);
    issue(MEM_LHU, 32'h2002, 32'h0, 1'b1, 5'd9, 32'h0, 1'b1, 0);
    issue(MEM_LW, 32'h3002, 32'h0, 1'b1, 5'd10, 32'h5555, 1'b1, 0);
    issue(MEM_LW, 32'h1008, 32'h0, 1'b1, 5'd11, 32'h0, 1'b1, 0);
    issue(MEM_SW, 32'h100C, 32'hCAFE_F00D, 1'b0, 5'd0, 32'h0, 1'b1, 0);
    issue(MEM_NOP, 32'h0, 32'h0, 1'b1, 5'd12, 32'h7777, 1'b1, 0);
    issue(MEM_LW, 32'h100C, 32'h0, 1'b1, 5'd13, 32'h0, 1'b1, 0);

    // Randomized traffic with random grant and read latency
    gnt_mode = 0;
    rv_max   = 2;
    for (int i = 0; i < 300; i++)
      issue(4'($urandom_range(0, 15)), 32'h1000 | 32'($urandom_range(0, 63)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom), $urandom, 1'b0, 0);

    // Reset while waiting for read data; the late rvalid must be ignored
    gnt_mode = 1;
    rv_max   = 0;
    hold_rv  = 1'b1;
    bus_q.push_back('{we: 1'b0, addr: 32'h1010, be: 4'hF, wdata: 32'h0});
    mem_op_i    = MEM_LW;
    mem_addr_i  = 32'h1010;
    reg_we_i    = 1'b1;
    reg_waddr_i = 5'd9;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wait_req_low", 32'(dbus_req_o), 32'd0);
    check("wait_stall", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_wait_stall", 32'(stall_o), 32'd0);
    check("rst_wait_reg_we", 32'(reg_we_o), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    hold_rv = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("late_rvalid_reg_we", 32'(reg_we_o), 32'd0);
      check("late_rvalid_stall", 32'(stall_o), 32'd0);
      check("late_rvalid_req", 32'(dbus_req_o), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(MEM_NOP, 32'h0, 32'h0, 1'b1, 5'd3, 32'h00C0_FFEE, 1'b1, 0);

    // Reset while requesting drops the request at once
    gnt_mode    = 3;
    mem_op_i    = MEM_SW;
    mem_addr_i  = 32'h1020;
    mem_data_i  = 32'h1111_2222;
    reg_we_i    = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("req_held", 32'(dbus_req_o), 32'd1);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_req_drop", 32'(dbus_req_o), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    gnt_mode = 1;
    @(posedge clk);
    #1;
    issue(MEM_LW, 32'h1020, 32'h0, 1'b1, 5'd14, 32'h0, 1'b1, 0);
    idle_inputs();

    repeat (6) @(posedge clk);
    @(negedge clk);
    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    check("misalign_queue_drained", 32'(mis_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
